// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// gemm_pkg : constants, FSM state type and requantisation helpers shared by
//            the gemm pipeline stages.
// Revision  : 1.0
// ============================================================================
package gemm_pkg;

  localparam int ACC_W = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  // Round-half-up arithmetic right shift; one guard bit keeps the rounding add from wrapping.
  function automatic logic signed [ACC_W-1:0] gemm_round_shift(
    input logic signed [ACC_W-1:0] v,
    input logic        [4:0]       sh
  );
    logic        [ACC_W:0] half;
    logic signed [ACC_W:0] t;
    if (sh == 5'd0) return v;
    half = {{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1);
    t    = $signed({v[ACC_W-1], v}) + $signed(half);
    t    = t >>> sh;
    return t[ACC_W-1:0];
  endfunction

  // {above max, below min} of a w-bit signed range.
  function automatic logic [1:0] gemm_sat_flags(
    input logic signed [ACC_W-1:0] v,
    input int                      w
  );
    logic        [ACC_W-1:0] one;
    logic        [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    one = {{(ACC_W-1){1'b0}}, 1'b1};
    mag = (one << (w - 1)) - one;
    hi  = $signed(mag);
    lo  = $signed(~mag);
    return {(v > hi), (v < lo)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_requant_lane.sv
`default_nettype none
// ============================================================================
// gemm_requant_lane : combinational round / shift / saturate of one lane.
//                     GEMM_WB_RELU_EN clamps negative results to zero.
// Revision  : 1.0
// ============================================================================
module gemm_requant_lane #(
  parameter int WIDTH = 16,
  parameter int ACC_W = gemm_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic        [4:0]       i_shift,
  input  logic                    i_en,
  output logic        [WIDTH-1:0] o_q
);
  import gemm_pkg::*;

  logic signed [ACC_W-1:0] w_rs;
  logic        [1:0]       w_ovf;
  logic        [WIDTH-1:0] w_q;

  assign w_rs  = gemm_round_shift(i_sum, i_shift);
  assign w_ovf = gemm_sat_flags(w_rs, WIDTH);

  always_comb begin
    w_q = w_rs[WIDTH-1:0];
    if (w_ovf[1]) begin
      w_q = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_ovf[0]) begin
      w_q = {1'b1, {(WIDTH-1){1'b0}}};
    end
`ifdef GEMM_WB_RELU_EN
    if (w_q[WIDTH-1]) begin
      w_q = '0;
    end
`endif
  end

  assign o_q = i_en ? w_q : '0;

endmodule
`default_nettype wire

// File: rtl/gemm_psum_writeback.sv
`default_nettype none
// ============================================================================
// gemm_psum_writeback : accumulates psum rows across K-tiles in the accumulator
//                       SRAM and writes requantised rows to the ofmap SRAM.
//                       Optional fused ReLU: GEMM_WB_RELU_EN.
// Revision  : 1.0
// ============================================================================
module gemm_psum_writeback #(
  parameter int WIDTH           = 16,
  parameter int ACC_W           = gemm_pkg::ACC_W,
  parameter int J               = 20,
  parameter int SRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                m,
  input  logic [15:0]                n,
  input  logic [7:0]                 num_ktiles,
  input  logic [4:0]                 shift,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [J*ACC_W-1:0]         in_row,
  output logic                       acc_rd_en,
  output logic [SRAM_ADDR_WIDTH-1:0] acc_rd_addr,
  input  logic [J*ACC_W-1:0]         acc_rd_data,
  output logic                       acc_wr_en,
  output logic [SRAM_ADDR_WIDTH-1:0] acc_wr_addr,
  output logic [J*ACC_W-1:0]         acc_wr_data,
  output logic                       ofm_wr_en,
  output logic [SRAM_ADDR_WIDTH-1:0] ofm_wr_addr,
  output logic [J*WIDTH-1:0]         ofm_wr_data,
  output logic                       busy,
  output logic                       done
);
  import gemm_pkg::*;

  wb_state_e                  r_state;
  logic                       r_in_ready;
  logic                       r_busy;
  logic                       r_done;
  logic [15:0]                r_mlast;
  logic [15:0]                r_n;
  logic [7:0]                 r_ktlast;
  logic [7:0]                 r_kt;
  logic [4:0]                 r_shift;
  logic [SRAM_ADDR_WIDTH-1:0] r_row;

  logic                       r_s1_vld;
  logic                       r_s1_first;
  logic                       r_s1_last;
  logic                       r_s1_fwd;
  logic [SRAM_ADDR_WIDTH-1:0] r_s1_addr;
  logic [J*ACC_W-1:0]         r_s1_row;
  logic [J*ACC_W-1:0]         r_fwd_sum;

  logic                       w_accept;
  logic                       w_rd_en;
  logic                       w_row_last;
  logic                       w_kt_last;
  logic [J*ACC_W-1:0]         w_rd;
  logic [J*ACC_W-1:0]         w_sum;
  logic [J*WIDTH-1:0]         w_q;

  assign w_accept   = in_valid && r_in_ready;
  assign w_rd_en    = w_accept && (r_kt != 8'd0);
  assign w_row_last = (16'(r_row) == r_mlast);
  assign w_kt_last  = (r_kt == r_ktlast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mlast    <= '0;
      r_n        <= '0;
      r_ktlast   <= '0;
      r_kt       <= '0;
      r_shift    <= '0;
      r_row      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mlast  <= m - 16'd1;
            r_ktlast <= num_ktiles - 8'd1;
            r_n      <= n;
            r_shift  <= shift;
            r_row    <= '0;
            r_kt     <= '0;
            r_busy   <= 1'b1;
            if ((m == 16'd0) || (num_ktiles == 8'd0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            if (w_row_last) begin
              r_row <= '0;
              if (w_kt_last) begin
                r_kt       <= '0;
                r_state    <= DRAIN;
                r_in_ready <= 1'b0;
              end else begin
                r_kt <= r_kt + 8'd1;
              end
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        // The final row's S1 write happens during this single cycle.
        DRAIN: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b1;
      r_s1_last  <= 1'b0;
      r_s1_fwd   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_row   <= '0;
      r_fwd_sum  <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      // SRAM returns pre-write data when reading the row S1 is writing now.
      r_s1_fwd  <= w_rd_en && r_s1_vld && !r_s1_last && (r_s1_addr == r_row);
      r_fwd_sum <= w_sum;
      if (w_accept) begin
        r_s1_row   <= in_row;
        r_s1_addr  <= r_row;
        r_s1_first <= (r_kt == 8'd0);
        r_s1_last  <= w_kt_last;
      end
    end
  end

  assign w_rd = r_s1_fwd ? r_fwd_sum : acc_rd_data;

  for (genvar j = 0; j < J; j++) begin : g_lane
    logic [ACC_W-1:0] w_prev;
    assign w_prev = r_s1_first ? '0 : w_rd[j*ACC_W +: ACC_W];
    assign w_sum[j*ACC_W +: ACC_W] = r_s1_row[j*ACC_W +: ACC_W] + w_prev;

    gemm_requant_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_requant (
      .i_sum   (w_sum[j*ACC_W +: ACC_W]),
      .i_shift (r_shift),
      .i_en    (r_n > 16'(j)),
      .o_q     (w_q[j*WIDTH +: WIDTH])
    );
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign acc_rd_en   = w_rd_en;
  assign acc_rd_addr = r_row;
  assign acc_wr_en   = r_s1_vld && !r_s1_last;
  assign acc_wr_addr = r_s1_addr;
  assign acc_wr_data = acc_wr_en ? w_sum : '0;
  assign ofm_wr_en   = r_s1_vld && r_s1_last;
  assign ofm_wr_addr = r_s1_addr;
  assign ofm_wr_data = ofm_wr_en ? w_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_gemm_psum_writeback.sv
`default_nettype none
// Testbench for gemm_psum_writeback: table of directed jobs plus hand-written
// sequences for m==0, num_ktiles==0 and reset in the middle of a job.
module tb_gemm_psum_writeback;
  localparam int WIDTH = 16;
  localparam int ACC_W = 40;
  localparam int J     = 20;
  localparam int AW    = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [15:0]        m = '0;
  logic [15:0]        n = '0;
  logic [7:0]         num_ktiles = '0;
  logic [4:0]         shift = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [J*ACC_W-1:0] in_row = '0;
  logic               acc_rd_en;
  logic [AW-1:0]      acc_rd_addr;
  logic [J*ACC_W-1:0] acc_rd_data = '0;
  logic               acc_wr_en;
  logic [AW-1:0]      acc_wr_addr;
  logic [J*ACC_W-1:0] acc_wr_data;
  logic               ofm_wr_en;
  logic [AW-1:0]      ofm_wr_addr;
  logic [J*WIDTH-1:0] ofm_wr_data;
  logic               busy;
  logic               done;

  gemm_psum_writeback #(
    .WIDTH(WIDTH), .ACC_W(ACC_W), .J(J), .SRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n),
    .num_ktiles(num_ktiles), .shift(shift), .in_valid(in_valid),
    .in_ready(in_ready), .in_row(in_row), .acc_rd_en(acc_rd_en),
    .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_data(acc_wr_data), .ofm_wr_en(ofm_wr_en),
    .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Accumulator SRAM: one-cycle read latency, read-before-write.
  logic [J*ACC_W-1:0] acc_mem [1<<AW];
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
    if (acc_wr_en) acc_mem[acc_wr_addr] <= acc_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt = 0, ofm_cnt = 0, done_cnt = 0, last_ofm_cyc = 0, done_cyc = 0;
  int ofm_stamp [1<<AW];
  logic [J*WIDTH-1:0] ofm_mem [1<<AW];
  always @(negedge clk) begin
    if (acc_wr_en) acc_cnt++;
    if (ofm_wr_en) begin
      ofm_cnt++;
      ofm_mem[ofm_wr_addr]   = ofm_wr_data;
      ofm_stamp[ofm_wr_addr] = ofm_cnt;
      last_ofm_cyc           = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [J*WIDTH-1:0] got,
                           input logic [J*WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic int relu_adj(input int x);
`ifdef GEMM_WB_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [J*ACC_W-1:0] mk_row(input int v, input int alt);
    logic [J*ACC_W-1:0] r;
    for (int j = 0; j < J; j++)
      r[j*ACC_W +: ACC_W] = (alt != 0 && j % 2 == 1) ? ACC_W'(-v) : ACC_W'(v);
    return r;
  endfunction

  function automatic logic [J*WIDTH-1:0] exp_row(input int nn, input int alt,
                                                 input int ev, input int od);
    logic [J*WIDTH-1:0] r;
    int x;
    r = '0;
    for (int j = 0; j < J; j++) begin
      if (j < nn) begin
        x = relu_adj((alt != 0 && j % 2 == 1) ? od : ev);
        r[j*WIDTH +: WIDTH] = x[WIDTH-1:0];
      end
    end
    return r;
  endfunction

  typedef struct {
    int m, n, nkt, sh, v, alt, tog, poke, ev, od;
  } vec_t;
  vec_t tv [10];

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called and returns at posedge+1.
  task automatic pulse_start(input int mm, input int nn, input int kk, input int ss);
    m = 16'(mm); n = 16'(nn); num_ktiles = 8'(kk); shift = 5'(ss);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int rows, input int v, input int alt, input int tog,
                      input int poke, input string name);
    int step = 0;
    int sent = 0;
    while (sent < rows && step < rows * 4 + 100) begin
      in_valid = (tog == 0) || (step % 2 == 0);
      in_row   = mk_row(v, alt);
      if (poke != 0 && step == 3) begin
        start = 1'b1; m = 16'd0; n = 16'd1; num_ktiles = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      step++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_int($sformatf("%s rows accepted", name), sent, rows);
  endtask

  task automatic run_job(input vec_t t, input string name, input bit rst);
    int b_acc, b_ofm, b_done, g;
    if (rst) do_reset();
    b_acc = acc_cnt; b_ofm = ofm_cnt; b_done = done_cnt;
    pulse_start(t.m, t.n, t.nkt, t.sh);
    @(negedge clk);
    check_int($sformatf("%s busy after start", name), int'(busy), 1);
    @(posedge clk); #1;
    feed(t.m * t.nkt, t.v, t.alt, t.tog, t.poke, name);
    g = 0;
    while (done_cnt == b_done && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    repeat (3) @(negedge clk);
    #1;
    check_int($sformatf("%s done pulses", name), done_cnt - b_done, 1);
    check_int($sformatf("%s acc writes", name), acc_cnt - b_acc, t.m * (t.nkt - 1));
    check_int($sformatf("%s ofm writes", name), ofm_cnt - b_ofm, t.m);
    check_int($sformatf("%s done latency", name), done_cyc - last_ofm_cyc, 1);
    check_int($sformatf("%s busy idle", name), int'(busy), 0);
    for (int r = 0; r < t.m; r++)
      check_vec($sformatf("%s row %0d", name, r),
                (ofm_stamp[r] > b_ofm) ? ofm_mem[r] : {(J*WIDTH){1'b1}},
                exp_row(t.n, t.alt, t.ev, t.od));
    @(posedge clk); #1;
  endtask

  task automatic run_empty(input int mm, input int kk, input string name);
    int b_acc, b_ofm, b_done;
    do_reset();
    b_acc = acc_cnt; b_ofm = ofm_cnt; b_done = done_cnt;
    pulse_start(mm, 4, kk, 0);
    @(negedge clk);
    check_int($sformatf("%s done next cycle", name), int'(done), 1);
    repeat (4) @(negedge clk);
    check_int($sformatf("%s writes", name), (acc_cnt - b_acc) + (ofm_cnt - b_ofm), 0);
    check_int($sformatf("%s done pulses", name), done_cnt - b_done, 1);
    check_int($sformatf("%s busy idle", name), int'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_acc, b_ofm;
    //        m   n  nkt sh  v        alt tog poke ev      od
    tv[0] = '{3,  4, 1,  0,  5,       0,  0,  0,   5,      5};
    tv[1] = '{12, 4, 2,  2,  10,      0,  0,  0,   5,      5};
    tv[2] = '{1,  20, 3, 0,  7,       0,  0,  0,   21,     21};
    tv[3] = '{2,  20, 1, 0,  100000,  1,  0,  0,   32767,  -32768};
    tv[4] = '{12, 4, 2,  2,  10,      0,  1,  1,   5,      5};
    tv[5] = '{2,  3, 1,  3,  -13,     1,  0,  0,   -2,     2};
    tv[6] = '{4,  20, 2, 1,  -3,      0,  0,  0,   -3,     -3};
    tv[7] = '{1,  20, 3, 0,  7,       0,  1,  0,   21,     21};
    tv[8] = '{2,  2, 1,  16, 100000,  1,  0,  0,   2,      -2};
    tv[9] = '{2,  20, 3, 0,  20000,   1,  0,  0,   32767,  -32768};

    repeat (3) @(negedge clk);
    check_vec("reset outputs",
              {{(J*WIDTH-6){1'b0}}, in_ready, busy, done, acc_wr_en, ofm_wr_en, acc_rd_en}
                | ofm_wr_data | acc_wr_data[J*WIDTH-1:0], '0);

    for (int i = 0; i < 10; i++) run_job(tv[i], $sformatf("vec%0d", i), 1'b1);

    run_empty(0, 1, "m0");
    run_empty(3, 0, "kt0");

    // Abandon a 12-row job after 5 rows; row 4's write is in flight when reset hits.
    do_reset();
    b_ofm = ofm_cnt;
    pulse_start(12, 4, 1, 0);
    feed(5, 5, 0, 0, 0, "midreset");
    check_int("midreset writes before reset", ofm_cnt - b_ofm, 4);
    b_acc = acc_cnt; b_ofm = ofm_cnt;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_vec("midreset outputs",
              {{(J*WIDTH-6){1'b0}}, in_ready, busy, done, acc_wr_en, ofm_wr_en, acc_rd_en}
                | ofm_wr_data, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    check_int("midreset writes after reset", (acc_cnt - b_acc) + (ofm_cnt - b_ofm), 0);
    run_job(tv[0], "post-reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
